// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Multi-cycle load/store unit for the RV32I core. Accepts one access from
//   the core, drives a word-organised data SRAM through a req/gnt/rvalid
//   handshake, formats load data and stalls the core until the access ends.
//   Misaligned accesses and illegal funct3 codes are rejected without ever
//   raising mem_req.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   req_valid           core presents an access (held until rsp_valid)
//   req_we              1 = store, 0 = load
//   req_funct3          RV32I funct3 of the access
//   req_addr            byte address
//   req_wdata           store data (rs2)
//   stall               core must hold PC/instruction
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata           formatted load data (0 for stores and errors)
//   misaligned          access rejected (meaningful with rsp_valid)
//   mem_req/mem_we      memory request / write
//   mem_be              byte enables
//   mem_addr            word address
//   mem_wdata           lane-replicated write data
//   mem_gnt             request accepted this cycle
//   mem_rvalid          read data valid (never with gnt)
//   mem_rdata           read word
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              misaligned,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic              we_r;
  logic [2:0]        funct3_r;
  logic [1:0]        off_r;
  logic              err_s;
  logic              stall_s;
  logic              mem_req_r;
  logic              mem_we_r;
  logic [3:0]        mem_be_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_wdata_r;
  logic              rsp_valid_r;
  logic              misaligned_r;
  logic [31:0]       rsp_rdata_r;
  logic              unused_s;

  // Access is rejected for an illegal funct3 or a size-misaligned address.
  function automatic logic access_error(input logic       we,
                                        input logic [2:0] f3,
                                        input logic [1:0] off);
    logic illegal;
    logic mis;
    if (we) begin
      illegal = (f3 > 3'd2);
    end else begin
      illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    end
    mis = ((f3[1:0] == 2'b01) && off[0]) ||
          ((f3[1:0] == 2'b10) && (off != 2'b00));
    return illegal | mis;
  endfunction

  // Byte enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] store_be(input logic [2:0] f3,
                                          input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the store data across all lanes so any byte enable picks it up.
  function automatic logic [31:0] store_lanes(input logic [2:0]  f3,
                                              input logic [31:0] wd);
    logic [31:0] lanes;
    case (f3[1:0])
      2'b00:   lanes = {4{wd[7:0]}};
      2'b01:   lanes = {2{wd[15:0]}};
      2'b10:   lanes = wd;
      default: lanes = 32'h0000_0000;
    endcase
    return lanes;
  endfunction

  // Select the addressed byte/halfword and sign- or zero-extend it.
  function automatic logic [31:0] load_format(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'b00:   b = rd[7:0];
      2'b01:   b = rd[15:8];
      2'b10:   b = rd[23:16];
      2'b11:   b = rd[31:24];
      default: b = 8'h00;
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'd0:    res = {{24{b[7]}}, b};
      3'd1:    res = {{16{h[15]}}, h};
      3'd2:    res = rd;
      3'd4:    res = {24'h00_0000, b};
      3'd5:    res = {16'h0000, h};
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // Error classification of the access presented by the core.
  always_comb begin
    err_s = access_error(req_we, req_funct3, req_addr[1:0]);
  end

  // Next-state logic; DONE always returns to IDLE so a held req is not re-taken.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_nxt_s = err_s ? DONE : REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_nxt_s = we_r ? DONE : WAIT;
        end else begin
          state_nxt_s = REQ;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Stall must react in the same cycle the core presents an access.
  always_comb begin
    if (state_r == IDLE) begin
      stall_s = req_valid;
    end else begin
      stall_s = (state_r == REQ) || (state_r == WAIT);
    end
  end

  // State, latched request and registered memory/response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      we_r         <= 1'b0;
      funct3_r     <= 3'd0;
      off_r        <= 2'd0;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_be_r     <= 4'b0000;
      mem_addr_r   <= '0;
      mem_wdata_r  <= 32'h0000_0000;
      rsp_valid_r  <= 1'b0;
      misaligned_r <= 1'b0;
      rsp_rdata_r  <= 32'h0000_0000;
    end else begin
      state_r     <= state_nxt_s;
      // mem_req and rsp_valid are registered decodes of the next state.
      mem_req_r   <= (state_nxt_s == REQ);
      rsp_valid_r <= (state_nxt_s == DONE);
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            we_r        <= req_we;
            funct3_r    <= req_funct3;
            off_r       <= req_addr[1:0];
            mem_we_r    <= req_we;
            mem_addr_r  <= req_addr[ADDR_W+1:2];
            mem_be_r    <= req_we ? store_be(req_funct3, req_addr[1:0]) : 4'b1111;
            mem_wdata_r <= req_we ? store_lanes(req_funct3, req_wdata) : 32'h0000_0000;
            if (err_s) begin
              misaligned_r <= 1'b1;
              rsp_rdata_r  <= 32'h0000_0000;
            end
          end
        end
        REQ: begin
          if (mem_gnt && we_r) begin
            misaligned_r <= 1'b0;
            rsp_rdata_r  <= 32'h0000_0000;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            misaligned_r <= 1'b0;
            rsp_rdata_r  <= load_format(funct3_r, off_r, mem_rdata);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Upper byte-address bits beyond the SRAM window are intentionally dropped.
  assign unused_s   = ^req_addr[31:ADDR_W+2];

  assign stall      = stall_s;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_rdata  = rsp_rdata_r;
  assign misaligned = misaligned_r;
  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign mem_be     = mem_be_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//   Directed and randomized stimulus for load_store_unit, checked against a
//   behavioural model of the access rules (sizes, lanes, extension, latency).
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misaligned;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  load_store_unit #(.ADDR_W(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .misaligned (misaligned),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---- reference model ----------------------------------------------------
  function automatic bit model_err(input bit we, input int f3, input logic [31:0] addr);
    int size;
    if (we && f3 > 2) return 1'b1;
    if (!we && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
    size = 1 << (f3 % 4);
    return (addr % size) != 0;
  endfunction

  function automatic logic [31:0] model_load(input int f3, input int off, input logic [31:0] word);
    int unsigned b;
    int unsigned h;
    b = (word >> (8 * off)) & 255;
    h = (word >> (16 * (off / 2))) & 65535;
    case (f3)
      0:       return (b >= 128) ? b - 256 : b;
      1:       return (h >= 32768) ? h - 65536 : h;
      2:       return word;
      4:       return b;
      5:       return h;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input bit we, input int f3, input int off);
    if (!we) return 4'hF;
    case (f3)
      0:       return 4'(1 << off);
      1:       return 4'(3 << off);
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input int f3, input logic [31:0] w);
    case (f3)
      0:       return (w & 32'hFF) * 32'h0101_0101;
      1:       return (w & 32'hFFFF) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  // ---- helpers -----------------------------------------------------------
  task automatic check_all_zero(input string pfx);
    check({pfx, "_stall"}, stall, 32'd0);
    check({pfx, "_rsp_valid"}, rsp_valid, 32'd0);
    check({pfx, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({pfx, "_misaligned"}, misaligned, 32'd0);
    check({pfx, "_mem_req"}, mem_req, 32'd0);
    check({pfx, "_mem_we"}, mem_we, 32'd0);
    check({pfx, "_mem_be"}, mem_be, 32'd0);
    check({pfx, "_mem_addr"}, mem_addr, 32'd0);
    check({pfx, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  task automatic apply_reset();
    reset = 1'b1; req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(posedge clk); #1;
    check_all_zero("reset");
    reset = 1'b0;
  endtask

  // Idle cycles with stray rvalid pulses that must be ignored.
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid  = 1'b0;
      mem_gnt    = 1'b0;
      mem_rvalid = ($urandom_range(0, 2) == 0);
      mem_rdata  = $urandom;
      #1;
      check("gap_stall", stall, 32'd0);
      check("gap_req", mem_req, 32'd0);
      check("gap_rsp", rsp_valid, 32'd0);
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;
  endtask

  // One access from presentation to response; req_valid stays high through
  // DONE, as a stalled core would hold it.  Entered and left at posedge+1.
  task automatic do_access(input bit we, input int f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int gd, input int rd,
                           input logic [31:0] word);
    bit          err;
    int          off;
    int          exp_lat;
    int          exp_nreq;
    logic [31:0] exp_rdata;
    int          cyc;
    int          gcnt;
    int          rvcnt;
    int          nreq;
    bit          granted;
    bit          got;
    off       = addr % 4;
    err       = model_err(we, f3, addr);
    exp_rdata = (err || we) ? 32'd0 : model_load(f3, off, word);
    exp_lat   = err ? 1 : (we ? 2 + gd : 3 + gd + rd);
    exp_nreq  = err ? 0 : gd + 1;
    check("start_req", mem_req, 32'd0);
    check("start_rsp", rsp_valid, 32'd0);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = 3'(f3);
    req_addr   = addr;
    req_wdata  = wdata;
    cyc = 0; gcnt = 0; rvcnt = 0; nreq = 0; granted = 1'b0; got = 1'b0;
    while (!got && cyc < 40) begin
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (rsp_valid) begin
        got = 1'b1;
        check("rsp_latency", cyc, exp_lat);
        check("rsp_misaligned", misaligned, err);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("mem_req_count", nreq, exp_nreq);
        check("done_mem_req", mem_req, 32'd0);
        #1;
        check("done_stall", stall, 32'd0);
      end else begin
        if (mem_req) begin
          nreq++;
          check("mem_addr", mem_addr, (addr >> 2) & 32'hFFF);
          check("mem_be", mem_be, model_be(we, f3, off));
          check("mem_we", mem_we, we);
          if (we) check("mem_wdata", mem_wdata, model_wdata(f3, wdata));
          if (gcnt == gd) begin
            mem_gnt = 1'b1;
            granted = 1'b1;
          end else begin
            gcnt++;
            mem_rvalid = ($urandom_range(0, 3) == 0);
          end
        end else if (granted && !we) begin
          if (rvcnt == rd) begin
            mem_rvalid = 1'b1;
            mem_rdata  = word;
          end else begin
            rvcnt++;
          end
        end
        #1;
        check("busy_stall", stall, 32'd1);
      end
      @(posedge clk); #1;
      cyc++;
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (!got) begin
      check("rsp_timeout", 32'd0, 32'd1);
      apply_reset();
    end
  endtask

  // ---- main sequence -----------------------------------------------------
  initial begin
    bit          we;
    int          f3;
    logic [31:0] addr;
    int          size;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    @(posedge clk); #1;
    apply_reset();
    gap(2);

    // Directed cases.
    do_access(1'b1, 0, 32'h0000_0103, 32'h1234_56AB, 0, 0, 32'd0);   // SB
    gap(1);
    do_access(1'b0, 0, 32'h0000_0202, 32'd0, 0, 0, 32'h0080_0000);   // LB
    do_access(1'b0, 4, 32'h0000_0202, 32'd0, 0, 0, 32'h0080_0000);   // LBU back-to-back
    do_access(1'b0, 1, 32'h0000_0202, 32'd0, 0, 0, 32'h8001_0000);   // LH
    do_access(1'b1, 1, 32'h0000_0101, 32'hCAFE_F00D, 0, 0, 32'd0);   // SH misaligned
    do_access(1'b0, 2, 32'h0000_0102, 32'd0, 0, 0, 32'h1111_2222);   // LW misaligned
    do_access(1'b0, 2, 32'h0000_0F04, 32'd0, 3, 2, 32'hDEAD_BEEF);   // LW slow memory
    do_access(1'b1, 3, 32'h0000_0010, 32'h0BAD_0BAD, 0, 0, 32'd0);   // illegal store
    gap(1);

    // Reset while waiting for read data, then a late rvalid.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0000_0300;
    @(posedge clk); #1;
    check("rw_req", mem_req, 32'd1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    check("rw_wait_req", mem_req, 32'd0);
    check("rw_wait_stall", stall, 32'd1);
    reset = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check_all_zero("rw_after");
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    check("rw_late_rsp", rsp_valid, 32'd0);
    check("rw_late_stall", stall, 32'd0);
    check("rw_late_req", mem_req, 32'd0);
    @(posedge clk); #1;
    check("rw_late_rsp2", rsp_valid, 32'd0);
    do_access(1'b1, 2, 32'h0000_0040, 32'h0102_0304, 1, 0, 32'd0);   // SW after reset

    // Randomized accesses.
    for (int n = 0; n < 200; n++) begin
      we = $urandom_range(0, 1);
      if ($urandom_range(0, 4) == 0) begin
        f3 = $urandom_range(0, 7);
      end else if (we) begin
        f3 = $urandom_range(0, 2);
      end else begin
        case ($urandom_range(0, 4))
          0:       f3 = 0;
          1:       f3 = 1;
          2:       f3 = 2;
          3:       f3 = 4;
          default: f3 = 5;
        endcase
      end
      addr = $urandom;
      size = 1 << (f3 % 4);
      if ($urandom_range(0, 3) != 0) addr = addr - (addr % size);
      do_access(we, f3, addr, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 1) == 0) gap($urandom_range(1, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
